// File: rtl/axi_injector_pkg.sv
// Shared definitions for the AXI-lite event injector.
//   - Fallback AXI-lite widths and response codes, used when the shared AXI
//     defines have not already been provided.
//   - inj_state_e: controller states.
//   - level_width(): width of a queue occupancy count for a given depth.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef RESP_OKAY
`define RESP_OKAY 2'b00
`endif

package axi_injector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_WRITE = 2'd1,
    INJ_REQ  = 2'd2,
    INJ_RESP = 2'd3
  } inj_state_e;

  // Occupancy has to represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_axi_light.sv
// AXI-lite bundle (AW, W, B, AR, R channels).
//   modport master: drives requests and the response ready signals.
//   modport slave : drives the request ready signals and the responses.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light;
  logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                   awprot;
  logic                         awvalid;
  logic                         awready;
  logic [`AXI_DATA_WIDTH-1:0]   wdata;
  logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                         wvalid;
  logic                         wready;
  logic [1:0]                   bresp;
  logic                         bvalid;
  logic                         bready;
  logic [`AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                   arprot;
  logic                         arvalid;
  logic                         arready;
  logic [`AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                   rresp;
  logic                         rvalid;
  logic                         rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_injector_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output.
//   clk, res_n   : clock, asynchronous active-low reset
//   push / din   : write request and data (dropped when full and not popping)
//   pop / dout   : read request and current head (dout valid when !empty)
//   full, empty  : status
//   level        : number of stored entries (0..DEPTH)
// A push is accepted when full if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as present.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/axi_injector.sv
// axi_injector: in-line AXI-lite block that turns hardware events into
// writes to a fixed address and merges them with upstream write traffic.
//   clk, res_n : clock, asynchronous active-low reset
//   sig, data  : event strobe and payload, sampled every rising edge
//   busy       : controller not idle or events still queued
//   overflow   : one-cycle pulse when an event was dropped (queue full)
//   err        : one-cycle pulse when an injected write got a non-OKAY bresp
//   level      : event queue occupancy
//   s_axi      : upstream port (from master)
//   m_axi      : downstream port (to slave)
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high; a valid, once raised, holds with stable payload until that edge,
// and ready may depend combinationally on valid.
module axi_injector
  import axi_injector_pkg::*;
#(
  parameter logic [`AXI_ADDR_WIDTH-1:0]   ADDR_INJECT  = 32'h00FF_FFF8,
  parameter int                           DEPTH        = 2,
  parameter bit                           PRIO_INJECT  = 1'b1,
  parameter logic [`AXI_DATA_WIDTH/8-1:0] WSTRB_INJECT = '1
) (
  input  logic                              clk,
  input  logic                              res_n,
  input  logic                              sig,
  input  logic [`AXI_DATA_WIDTH-1:0]        data,
  output logic                              busy,
  output logic                              overflow,
  output logic                              err,
  output logic [level_width(DEPTH)-1:0]     level,
  if_axi_light.slave                        s_axi,
  if_axi_light.master                       m_axi
);
  inj_state_e state_q, state_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic overflow_q, overflow_d;
  logic err_q, err_d;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [`AXI_DATA_WIDTH-1:0] fifo_dout;
  logic                       up_req;
  logic                       in_req;
  logic                       aw_hs;
  logic                       w_hs;

  sync_fifo #(
    .WIDTH (`AXI_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (sig),
    .pop   (fifo_pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign up_req = s_axi.awvalid | s_axi.wvalid;
  assign in_req = (state_q == INJ_REQ);
  assign aw_hs  = awvalid_q & m_axi.awready;
  assign w_hs   = wvalid_q & m_axi.wready;

  // AW and W retire independently; a done flag remembers an accepted channel
  // so its valid stays low until the other one is accepted too.
  assign aw_done_d  = in_req & (aw_done_q | aw_hs);
  assign w_done_d   = in_req & (w_done_q | w_hs);
  assign awvalid_d  = in_req & ~aw_done_d;
  assign wvalid_d   = in_req & ~w_done_d;
  // A pop in the same cycle frees a slot, so the event is not dropped.
  assign overflow_d = sig & fifo_full & ~fifo_pop;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (PRIO_INJECT || !up_req)) state_d = INJ_REQ;
        else if (up_req)                             state_d = UP_WRITE;
      end
      UP_WRITE: begin
        if (m_axi.bvalid && s_axi.bready) state_d = IDLE;
      end
      INJ_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = INJ_RESP;
      end
      INJ_RESP: begin
        // Response is consumed here; failures are flagged, never retried.
        if (m_axi.bvalid) begin
          fifo_pop = 1'b1;
          err_d    = (m_axi.bresp != `RESP_OKAY);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write channel steering.
  always_comb begin
    m_axi.awaddr  = s_axi.awaddr;
    m_axi.awprot  = s_axi.awprot;
    m_axi.wdata   = s_axi.wdata;
    m_axi.wstrb   = s_axi.wstrb;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bresp   = m_axi.bresp;
    case (state_q)
      UP_WRITE: begin
        m_axi.awvalid = s_axi.awvalid;
        s_axi.awready = m_axi.awready;
        m_axi.wvalid  = s_axi.wvalid;
        s_axi.wready  = m_axi.wready;
        s_axi.bvalid  = m_axi.bvalid;
        m_axi.bready  = s_axi.bready;
      end
      INJ_REQ: begin
        m_axi.awaddr  = ADDR_INJECT;
        m_axi.awprot  = 3'b000;
        m_axi.wdata   = fifo_dout;
        m_axi.wstrb   = WSTRB_INJECT;
        m_axi.awvalid = awvalid_q;
        m_axi.wvalid  = wvalid_q;
      end
      INJ_RESP: begin
        m_axi.bready  = 1'b1;
      end
      default: ;
    endcase
  end

  // Read channels are never touched.
  assign m_axi.araddr  = s_axi.araddr;
  assign m_axi.arprot  = s_axi.arprot;
  assign m_axi.arvalid = s_axi.arvalid;
  assign s_axi.arready = m_axi.arready;
  assign s_axi.rdata   = m_axi.rdata;
  assign s_axi.rresp   = m_axi.rresp;
  assign s_axi.rvalid  = m_axi.rvalid;
  assign m_axi.rready  = s_axi.rready;

  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign overflow = overflow_q;
  assign err      = err_q;
endmodule

// File: tb/tb_axi_injector.sv
// Bench for axi_injector: a randomized downstream slave logs every completed
// write, and a queue model of the expected write order is built from the
// events and upstream writes the bench issues.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_injector;
  localparam logic [31:0] ADDR_INJ = 32'h00FF_FFF8;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic sig = 1'b0;
  logic [31:0] data = '0;
  logic busy, overflow, err;
  logic [1:0] level;

  if_axi_light s_if ();
  if_axi_light m_if ();

  axi_injector #(
    .ADDR_INJECT (ADDR_INJ),
    .DEPTH (DEPTH),
    .PRIO_INJECT (1'b1),
    .WSTRB_INJECT (4'hF)
  ) dut (
    .clk (clk),
    .res_n (res_n),
    .sig (sig),
    .data (data),
    .busy (busy),
    .overflow (overflow),
    .err (err),
    .level (level),
    .s_axi (s_if),
    .m_axi (m_if)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [67:0] exp_q[$];   // {wstrb, addr, data} in expected order
  logic [67:0] obs_q[$];   // as completed at the slave
  int model_lvl = 0;
  int exp_ovf = 0;
  int ovf_seen = 0;
  int err_seen = 0;
  int stray = 0;
  bit up_busy = 0;

  // slave knobs and state
  bit stall_aw = 0;
  bit stall_w = 0;
  int rdy_pct = 100;
  int err_pct = 0;
  bit force_err = 0;
  int err_inj_sent = 0;
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] b_pend[$];
  bit b_active = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- downstream slave ----------------
  initial begin : slave
    logic [31:0] a;
    logic [35:0] sw;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        aw_q.delete(); w_q.delete(); b_pend.delete(); b_active = 0;
      end else begin
        if (m_if.awvalid && m_if.awready) aw_q.push_back(m_if.awaddr);
        if (m_if.wvalid && m_if.wready) w_q.push_back({m_if.wstrb, m_if.wdata});
        if (m_if.bvalid && m_if.bready) begin
          b_active = 0;
          b_pend.delete(0);
        end
        while (aw_q.size() > 0 && w_q.size() > 0) begin
          a = aw_q.pop_front();
          sw = w_q.pop_front();
          obs_q.push_back({sw[35:32], a, sw[31:0]});
          b_pend.push_back(a);
        end
      end
      @(posedge clk); #1;
      if (!res_n) begin
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 2'b00;
      end else begin
        m_if.awready = !stall_aw && ($urandom_range(1, 100) <= rdy_pct);
        m_if.wready  = !stall_w && ($urandom_range(1, 100) <= rdy_pct);
        if (!b_active && b_pend.size() > 0 && $urandom_range(1, 100) <= rdy_pct) begin
          b_active = 1;
          m_if.bvalid = 1;
          if (force_err || $urandom_range(1, 100) <= err_pct) begin
            m_if.bresp = 2'b10;
            force_err = 0;
            if (b_pend[0] == ADDR_INJ) err_inj_sent++;
          end else begin
            m_if.bresp = 2'b00;
          end
        end else if (!b_active) begin
          m_if.bvalid = 0;
        end
      end
    end
  end

  // ---------------- pulse monitors ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (overflow) ovf_seen++;
      if (err) err_seen++;
      if (s_if.bvalid && !up_busy) stray++;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Event pulse; the model queues it if there is room, else expects a drop.
  task automatic pulse(input logic [31:0] d);
    sig = 1; data = d;
    if (model_lvl < DEPTH) begin
      exp_q.push_back({4'hF, ADDR_INJ, d});
      model_lvl++;
    end else begin
      exp_ovf++;
    end
    @(posedge clk); #1;
    sig = 0;
  endtask

  task automatic up_write(input logic [31:0] a, input logic [31:0] d,
                          output logic got_b, output logic [1:0] r);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    got_b = 0; r = 2'b00;
    up_busy = 1;
    s_if.awaddr = a; s_if.awprot = 3'b000; s_if.wdata = d; s_if.wstrb = 4'h3;
    s_if.awvalid = 1; s_if.wvalid = 1; s_if.bready = 1;
    while (!got_b && n < 2000) begin
      @(negedge clk);
      n++;
      if (s_if.awvalid && s_if.awready) aw_done = 1;
      if (s_if.wvalid && s_if.wready) w_done = 1;
      if (s_if.bvalid && s_if.bready) begin
        got_b = 1;
        r = s_if.bresp;
      end
      @(posedge clk); #1;
      if (aw_done) s_if.awvalid = 0;
      if (w_done) s_if.wvalid = 0;
    end
    s_if.awvalid = 0; s_if.wvalid = 0; s_if.bready = 0;
    up_busy = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    stall_aw = 0; stall_w = 0;
    while ((busy || up_busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, 128'(n < 3000), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_nwrites"}, 128'(obs_q.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_write"}, 128'(obs_q.pop_front()), 128'(exp_q.pop_front()));
    exp_q.delete(); obs_q.delete();
    chk({tag, "_ovf"}, 128'(ovf_seen), 128'(exp_ovf));
    chk({tag, "_err"}, 128'(err_seen), 128'(err_inj_sent));
    chk({tag, "_level"}, 128'(level), 128'(0));
    model_lvl = 0;
  endtask

  // ---------------- main sequence ----------------
  logic got_b;
  logic [1:0] br;
  logic [31:0] rd, d0, d1;
  int k;

  initial begin : main
    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 0; s_if.wdata = '0;
    s_if.wstrb = '0; s_if.wvalid = 0; s_if.bready = 0;
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 0; s_if.rready = 0;
    m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", {busy, overflow, err, level}, 0);
    chk("rst_m_write", {m_if.awvalid, m_if.wvalid, m_if.bready}, 0);
    chk("rst_s_write", {s_if.awready, s_if.wready, s_if.bvalid}, 0);
    #2 res_n = 1;
    @(posedge clk); #1;

    // single event, fixed latency
    pulse(32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("lat_n1_valid", {m_if.awvalid, m_if.wvalid}, 2'b00);
    chk("lat_n1_busy", busy, 1);
    @(posedge clk); #1;
    chk("lat_n2_valid", {m_if.awvalid, m_if.wvalid}, 2'b11);
    chk("lat_awaddr", m_if.awaddr, ADDR_INJ);
    chk("lat_wdata", m_if.wdata, 32'hDEAD_BEEF);
    chk("lat_strb_prot", {m_if.wstrb, m_if.awprot}, {4'hF, 3'b000});
    @(posedge clk); #2;
    chk("inj_b_hidden", {s_if.bvalid, m_if.bready}, 2'b01);
    @(posedge clk); #1;
    chk("lat_done", {busy, level}, 0);
    drain("single");

    // overflow with stalled slave
    stall_aw = 1; stall_w = 1;
    pulse(32'd1); pulse(32'd2); pulse(32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_level", level, 2);
    chk("ovf_pulse", ovf_seen, 1);
    drain("overflow");

    // skewed AW/W acceptance
    stall_aw = 1; stall_w = 1;
    pulse($urandom());
    k = 0;
    while (!m_if.awvalid && k < 50) begin @(posedge clk); #1; k++; end
    chk("skew_awvalid_seen", 128'(k < 50), 128'(1));
    #2 stall_aw = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("skew_aw_drop", {m_if.awvalid, m_if.wvalid}, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    chk("skew_w_held", {m_if.wvalid, level}, {1'b1, 2'd1});
    #2 stall_w = 0;
    drain("skew");

    // error response
    force_err = 1;
    pulse($urandom());
    drain("error");
    chk("error_count", err_seen, 1);

    // queued event versus upstream write: event goes first
    d0 = $urandom();
    pulse(d0);
    exp_q.push_back({4'h3, 32'h100, 32'd5});
    up_write(32'h100, 32'd5, got_b, br);
    chk("coll_up_b", {got_b, br}, {1'b1, 2'b00});
    drain("coll_prio");

    // empty queue: upstream write and event together, upstream goes first
    d0 = $urandom();
    exp_q.push_back({4'h3, 32'h108, 32'd7});
    fork
      up_write(32'h108, 32'd7, got_b, br);
      pulse(d0);
    join
    chk("coll_empty_up_b", got_b, 1);
    drain("coll_empty");

    // fairness: full queue, upstream waits behind both entries; reads pass
    stall_aw = 1; stall_w = 1;
    d0 = $urandom(); d1 = $urandom();
    pulse(d0); pulse(d1);
    exp_q.push_back({4'h3, 32'h104, 32'hCAFE});
    fork
      up_write(32'h104, 32'hCAFE, got_b, br);
      begin
        repeat (3) @(posedge clk);
        #1;
        rd = $urandom();
        s_if.araddr = 32'h200; s_if.arprot = 3'b001; s_if.arvalid = 1; s_if.rready = 1;
        m_if.arready = 1; m_if.rdata = rd; m_if.rresp = 2'b10; m_if.rvalid = 1;
        #1;
        chk("rd_ar", {m_if.araddr, m_if.arprot, m_if.arvalid, m_if.rready}, {32'h200, 3'b001, 2'b11});
        chk("rd_r", {s_if.rdata, s_if.rresp, s_if.rvalid, s_if.arready}, {rd, 2'b10, 2'b11});
        chk("rd_busy", {busy, s_if.awready}, 2'b10);
        s_if.arvalid = 0; s_if.rready = 0; m_if.arready = 0; m_if.rvalid = 0;
        stall_aw = 0; stall_w = 0;
      end
    join
    chk("fair_up_b", got_b, 1);
    drain("fair");

    // reset while an injection is being requested
    stall_aw = 1; stall_w = 1;
    pulse($urandom()); pulse($urandom());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre_valid", {m_if.awvalid, m_if.wvalid}, 2'b11);
    #2 res_n = 0;
    #1;
    chk("rst_mid_valid", {m_if.awvalid, m_if.wvalid}, 2'b00);
    chk("rst_mid_status", {busy, level}, 0);
    repeat (2) @(posedge clk);
    #3 res_n = 1;
    exp_q.delete(); model_lvl = 0;
    stall_aw = 0; stall_w = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_replay", 128'(obs_q.size()), 128'(0));
    chk("rst_idle", busy, 0);

    // randomized bursts with random readiness, errors and upstream writes
    for (int it = 0; it < 10; it++) begin
      rdy_pct = $urandom_range(30, 100);
      err_pct = $urandom_range(0, 40);
      stall_aw = 1; stall_w = 1;
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) pulse($urandom());
      repeat (2) @(posedge clk);
      #1;
      chk("rnd_level", 128'(level), 128'((k < DEPTH) ? k : DEPTH));
      if ($urandom_range(0, 1) == 1) begin
        d0 = $urandom();
        d1 = $urandom() & 32'h0000_FFFC;
        exp_q.push_back({4'h3, d1, d0});
        fork
          up_write(d1, d0, got_b, br);
          begin
            repeat (2) @(posedge clk);
            #2 stall_aw = 0; stall_w = 0;
          end
        join
        chk("rnd_up_b", got_b, 1);
      end
      drain("rnd");
    end
    rdy_pct = 100; err_pct = 0;

    chk("stray_s_bvalid", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
